// File: rtl/icetea_sram_pkg.sv
// Shared definitions for the external 16-bit SRAM arbiter.
package icetea_sram_pkg;

  localparam int SRAM_AW           = 18;
  localparam int SRAM_DW           = 16;
  localparam int ACCESS_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Counts the strobe-asserted cycles of one SRAM access.
module sram_wait_counter
  import icetea_sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic last
);

  logic [3:0] wait_cnt;

  // Load on SETUP exit, then count down to zero while the access runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (load) begin
      wait_cnt <= 4'(ACCESS_CYCLES - 1);
    end else if (en && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign last = (wait_cnt == 4'd0);

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter that owns every SRAM pin and sequences its strobes.
// All SRAM outputs are registered from the next state so they never glitch.
module sram_arbiter
  import icetea_sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter bit FAIR          = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [SRAM_AW-1:0] a_addr,
  input  logic [SRAM_DW-1:0] a_wdata,
  output logic               a_ack,
  output logic [SRAM_DW-1:0] a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [SRAM_AW-1:0] b_addr,
  input  logic [SRAM_DW-1:0] b_wdata,
  output logic               b_ack,
  output logic [SRAM_DW-1:0] b_rdata,
  input  logic [SRAM_DW-1:0] sram_data_in,
  output logic [SRAM_DW-1:0] sram_data_out,
  output logic               sram_data_out_en,
  output logic [SRAM_AW-1:0] address_pins,
  output logic               RAMCS,
  output logic               RAMOE,
  output logic               RAMWE,
  output logic               busy,
  output logic               owner
);

  state_t             state, state_nx;
  logic               last;
  logic               grant, grant_b;
  logic               last_served;
  logic               we_l;
  logic [SRAM_AW-1:0] addr_l;
  logic [SRAM_DW-1:0] wdata_l;
  logic [SRAM_DW-1:0] rd_latch;
  logic               cur_we;
  logic [SRAM_AW-1:0] cur_addr;
  logic [SRAM_DW-1:0] cur_wdata;
  logic               cs_nx, oe_nx, we_nx, oen_nx;

  sram_wait_counter #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_wait (
    .clk   (clk),
    .reset (reset),
    .load  (state == SETUP),
    .en    (state == ACCESS),
    .last  (last)
  );

  // Arbitration, next state and next values of the SRAM strobes.
  always_comb begin
    grant     = 1'b0;
    grant_b   = 1'b0;
    state_nx  = state;
    cur_we    = we_l;
    cur_addr  = addr_l;
    cur_wdata = wdata_l;
    cs_nx     = 1'b1;
    oe_nx     = 1'b1;
    we_nx     = 1'b1;
    oen_nx    = 1'b0;

    // B wins a tie only when fairness is on and A was served last.
    if (a_req && b_req) begin
      grant   = 1'b1;
      grant_b = FAIR && !last_served;
    end else if (a_req || b_req) begin
      grant   = 1'b1;
      grant_b = b_req;
    end

    // In IDLE the strobes must follow the port being granted this edge.
    if (state == IDLE) begin
      cur_we    = grant_b ? b_we    : a_we;
      cur_addr  = grant_b ? b_addr  : a_addr;
      cur_wdata = grant_b ? b_wdata : a_wdata;
    end

    case (state)
      IDLE:    if (grant) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase

    case (state_nx)
      SETUP: begin
        cs_nx  = 1'b0;
        oe_nx  = cur_we;
        oen_nx = cur_we;
      end
      ACCESS: begin
        cs_nx  = 1'b0;
        oe_nx  = cur_we;
        we_nx  = !cur_we;
        oen_nx = cur_we;
      end
      DONE: begin
        cs_nx  = 1'b0;
        oen_nx = cur_we;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Registered SRAM pins; address and data hold their last value in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      RAMCS            <= 1'b1;
      RAMOE            <= 1'b1;
      RAMWE            <= 1'b1;
      sram_data_out_en <= 1'b0;
      address_pins     <= '0;
      sram_data_out    <= '0;
    end else begin
      RAMCS            <= cs_nx;
      RAMOE            <= oe_nx;
      RAMWE            <= we_nx;
      sram_data_out_en <= oen_nx;
      if (state_nx != IDLE) begin
        address_pins  <= cur_addr;
        sram_data_out <= cur_wdata;
      end
    end
  end

  // Grant bookkeeping; last_served starts at B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= 1'b0;
      last_served <= 1'b1;
      we_l        <= 1'b0;
    end else begin
      if (state == IDLE && grant) begin
        owner <= grant_b;
        we_l  <= cur_we;
      end
      if (state == DONE) last_served <= owner;
    end
  end

  // Latched request copy and read capture on the final ACCESS cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && grant) begin
      addr_l  <= cur_addr;
      wdata_l <= cur_wdata;
    end
    if (state == ACCESS && last && !we_l) rd_latch <= sram_data_in;
  end

  // Completion pulse and per-port read data, updated as DONE retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_ack <= (state == DONE) && !owner;
      b_ack <= (state == DONE) &&  owner;
      if (state == DONE && !we_l && !owner) a_rdata <= rd_latch;
      if (state == DONE && !we_l &&  owner) b_rdata <= rd_latch;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: a FAIR=1 arbiter on an SRAM model, plus a FAIR=0 arbiter
// on a pattern-returning SRAM for the strict-priority case.
module tb_sram_arbiter;
  import icetea_sram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [17:0] a_addr, b_addr, address_pins;
  logic [15:0] a_wdata, a_rdata, b_wdata, b_rdata;
  logic [15:0] sram_data_in, sram_data_out;
  logic        sram_data_out_en, RAMCS, RAMOE, RAMWE, busy, owner;

  logic        s_a_req, s_a_ack, s_b_req, s_b_ack;
  logic [17:0] s_a_addr, s_b_addr, s_address_pins;
  logic [15:0] s_a_rdata, s_b_rdata, s_sram_data_in, s_sram_data_out;
  logic        s_out_en, s_RAMCS, s_RAMOE, s_RAMWE, s_busy, s_owner;

  logic [15:0] mem [0:262143];
  logic        pl_en;
  logic [17:0] pl_addr;
  logic [15:0] pl_data;
  int          overlap_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  sram_arbiter #(.ACCESS_CYCLES(2), .FAIR(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out),
    .sram_data_out_en(sram_data_out_en), .address_pins(address_pins),
    .RAMCS(RAMCS), .RAMOE(RAMOE), .RAMWE(RAMWE), .busy(busy), .owner(owner)
  );

  sram_arbiter #(.ACCESS_CYCLES(2), .FAIR(1'b0)) u_strict (
    .clk(clk), .reset(reset),
    .a_req(s_a_req), .a_we(1'b0), .a_addr(s_a_addr), .a_wdata(16'h0),
    .a_ack(s_a_ack), .a_rdata(s_a_rdata),
    .b_req(s_b_req), .b_we(1'b0), .b_addr(s_b_addr), .b_wdata(16'h0),
    .b_ack(s_b_ack), .b_rdata(s_b_rdata),
    .sram_data_in(s_sram_data_in), .sram_data_out(s_sram_data_out),
    .sram_data_out_en(s_out_en), .address_pins(s_address_pins),
    .RAMCS(s_RAMCS), .RAMOE(s_RAMOE), .RAMWE(s_RAMWE), .busy(s_busy), .owner(s_owner)
  );

  assign sram_data_in   = (!RAMCS && !RAMOE) ? mem[address_pins] : 16'h0;
  assign s_sram_data_in = (!s_RAMCS && !s_RAMOE) ? (s_address_pins[15:0] ^ 16'hC3C3) : 16'h0;

  // SRAM model writes plus bench preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!RAMCS && !RAMWE && sram_data_out_en) mem[address_pins] <= sram_data_out;
  end

  // Count cycles in which both acks are high.
  always @(posedge clk) begin
    if (a_ack && b_ack) overlap_cnt <= overlap_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [17:0] addr, input logic [15:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    tick();
    pl_en = 1'b0;
  endtask

  initial begin
    int ack_at, we_low, bad_cs, unstable, n, a_cnt, b_cnt;
    int times [0:2];
    logic [3:0]  order;
    logic [15:0] exp6 [0:2];

    reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    s_a_req = 0; s_a_addr = '0; s_b_req = 0; s_b_addr = '0;
    tick(); tick();
    reset = 1'b0;

    check("rst_strobes", {RAMCS, RAMOE, RAMWE, sram_data_out_en}, 4'b1110);
    check("rst_addr", address_pins, 18'h0);
    check("rst_ctrl", {busy, owner, a_ack, b_ack}, 4'b0000);
    check("rst_rdata", {a_rdata, b_rdata}, 32'h0);

    preload(18'h00010, 16'h1234);
    preload(18'h00020, 16'hAAAA);
    preload(18'h00021, 16'h5555);
    preload(18'h00000, 16'h1111);
    preload(18'h00001, 16'h2222);
    preload(18'h00002, 16'h3333);

    // Reset during a write ACCESS
    a_we = 1; a_addr = 18'h5; a_wdata = 16'h7777; a_req = 1;
    tick();
    a_req = 0;
    tick();
    check("t1_in_access", {RAMCS, RAMWE}, 2'b00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t1_after_reset", {RAMWE, RAMCS, sram_data_out_en, busy, a_ack}, 5'b11000);
    a_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (a_ack) a_cnt++;
    end
    check("t1_no_ack", a_cnt, 0);

    // A read
    a_we = 0; a_addr = 18'h00010; a_req = 1;
    tick();
    a_req = 0;
    ack_at = -1; we_low = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (!RAMWE) we_low++;
      if (a_ack && ack_at < 0) begin
        ack_at = k;
        check("t2_rdata", a_rdata, 16'h1234);
      end
    end
    check("t2_latency", ack_at, 4);
    check("t2_ramwe_high", we_low, 0);
    check("t2_owner", owner, 1'b0);

    // A write at top address
    a_we = 1; a_addr = 18'h3FFFF; a_wdata = 16'hBEEF; a_req = 1;
    tick();
    a_req = 0;
    ack_at = -1; we_low = 0; bad_cs = 0; unstable = 0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      if (!RAMWE) we_low++;
      if (!RAMWE && RAMCS) bad_cs++;
      if (k <= 3 && (address_pins != 18'h3FFFF || sram_data_out != 16'hBEEF ||
                     !sram_data_out_en || RAMCS)) unstable++;
      if (a_ack && ack_at < 0) ack_at = k;
    end
    check("t3_we_low_cycles", we_low, 2);
    check("t3_we_inside_cs", bad_cs, 0);
    check("t3_addr_data_stable", unstable, 0);
    check("t3_ack", ack_at, 4);
    check("t3_mem", mem[18'h3FFFF], 16'hBEEF);
    check("t3_rdata_kept", a_rdata, 16'h1234);

    // Simultaneous requests with fairness
    reset = 1'b1; tick(); reset = 1'b0;
    a_we = 0; a_addr = 18'h20; b_we = 0; b_addr = 18'h21;
    a_req = 1; b_req = 1;
    n = 0; order = '0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      tick();
      if (a_ack || b_ack) begin
        order[n] = b_ack;
        if (a_ack) check("t4_a_rdata", a_rdata, 16'hAAAA);
        if (b_ack) check("t4_b_rdata", b_rdata, 16'h5555);
        n++;
        if (n == 4) begin a_req = 0; b_req = 0; end
      end
    end
    a_req = 0; b_req = 0;
    check("t4_ack_count", n, 4);
    check("t4_order", order, 4'b1010);
    tick();
    check("t4_idle", busy, 1'b0);

    // Strict priority
    s_a_addr = 18'h40; s_b_addr = 18'h77;
    s_a_req = 1; s_b_req = 1;
    a_cnt = 0; b_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (s_a_ack) a_cnt++;
      if (s_b_ack) b_cnt++;
    end
    check("t5_b_starved", b_cnt, 0);
    check("t5_a_acks", a_cnt, 6);
    check("t5_a_ack_at_drop", s_a_ack, 1'b1);
    check("t5_a_rdata", s_a_rdata, 16'h0040 ^ 16'hC3C3);
    s_a_req = 0;
    ack_at = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (s_b_ack && ack_at < 0) begin
        ack_at = k;
        s_b_req = 0;
      end
    end
    s_b_req = 0;
    check("t5_b_next_slot", ack_at, 5);
    check("t5_b_rdata", s_b_rdata, 16'h0077 ^ 16'hC3C3);

    // Back-to-back reads from A
    exp6[0] = 16'h1111; exp6[1] = 16'h2222; exp6[2] = 16'h3333;
    times[0] = 0; times[1] = 0; times[2] = 0;
    a_we = 0; a_addr = 18'h0; a_req = 1;
    n = 0;
    for (int k = 1; k <= 40 && n < 3; k++) begin
      tick();
      if (a_ack) begin
        times[n] = k;
        check("t6_rdata", a_rdata, exp6[n]);
        n++;
        if (n == 3) a_req = 0;
        else        a_addr = 18'(n);
      end
    end
    a_req = 0;
    check("t6_ack_count", n, 3);
    check("t6_spacing_01", times[1] - times[0], 5);
    check("t6_spacing_12", times[2] - times[1], 5);

    tick();
    check("no_ack_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
